// File: rtl/duck_pkg.sv
// Shared types and sprite constants for the duck motion controller.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
//   duck_state_t : lifecycle state, also exported on the duck_state output
//   FRAME_*      : sprite ROM base of each 20x16 frame (320 words per frame)
//   clamp_x      : saturates a launch x position into [lo, hi]
package duck_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FLY    = 3'd1,
      SHOT   = 3'd2,
      FALL   = 3'd3,
      ESCAPE = 3'd4
   } duck_state_t;

   localparam logic [18:0] FRAME_FLY_A = 19'd0;
   localparam logic [18:0] FRAME_FLY_B = 19'd320;
   localparam logic [18:0] FRAME_SHOT  = 19'd640;
   localparam logic [18:0] FRAME_FALL  = 19'd960;

   // "x <= lo" rather than "x < lo" keeps the test meaningful when lo is 0.
   function automatic logic [9:0] clamp_x(input logic [9:0] x,
                                          input logic [9:0] lo,
                                          input logic [9:0] hi);
      if (x <= lo)
         return lo;
      else if (x > hi)
         return hi;
      else
         return x;
   endfunction

endpackage

// File: rtl/duck_flight_ctrl_if.sv
// Bundle of the duck controller's game-side inputs and renderer/score outputs.
// Latency: none (wiring only).
// Backpressure: none; every signal is a level or a one-Clk pulse.
//   inputs : frame_clk, launch, start_x, dir_seed, shot_valid, shot_x, shot_y
//   outputs: duck_x, duck_y, sprite_base, duck_state, active, hit, escaped, landed
//   master = game/gun side that drives the inputs, slave = the controller
interface duck_flight_ctrl_if;
   import duck_pkg::*;

   logic              frame_clk;
   logic              launch;
   logic [9:0]        start_x;
   logic [1:0]        dir_seed;
   logic              shot_valid;
   logic [9:0]        shot_x;
   logic [9:0]        shot_y;
   logic [9:0]        duck_x;
   logic [9:0]        duck_y;
   logic [18:0]       sprite_base;
   duck_state_t       duck_state;
   logic              active;
   logic              hit;
   logic              escaped;
   logic              landed;

   modport master (
      output frame_clk, launch, start_x, dir_seed, shot_valid, shot_x, shot_y,
      input  duck_x, duck_y, sprite_base, duck_state, active, hit, escaped, landed
   );

   modport slave (
      input  frame_clk, launch, start_x, dir_seed, shot_valid, shot_x, shot_y,
      output duck_x, duck_y, sprite_base, duck_state, active, hit, escaped, landed
   );

endinterface

// File: rtl/frame_tick_sync.sv
// Synchronises the asynchronous VGA frame strobe and emits a one-Clk tick per rising edge.
// Latency: tick_o is high in the cycle after the second flop captures the edge (3 Clk to use).
// Backpressure: none; a tick is never held or queued.
//   clk_i   : system clock       rst_i  : async active-high reset
//   async_i : frame strobe       tick_o : one-cycle rising-edge pulse
module frame_tick_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic tick_o
);

   logic sync1_q;
   logic sync2_q;
   logic sync3_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= async_i;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign tick_o = sync2_q & ~sync3_q;

endmodule

// File: rtl/duck_flight_ctrl.sv
// Per-duck lifecycle FSM: launch, bouncing flight, hit detection, shot hold, fall and escape.
// Latency: position updates one Clk after a frame tick; hit pulses one Clk after shot_valid.
// Backpressure: none; launch outside IDLE and shots outside FLY are dropped.
//   Clk, Reset : system clock, async active-high reset
//   bus        : duck_flight_ctrl_if.slave (game inputs in, position/sprite/events out)
module duck_flight_ctrl
   import duck_pkg::*;
#(
   parameter logic [9:0] X_MIN         = 10'd0,
   parameter logic [9:0] X_MAX         = 10'd639,
   parameter logic [9:0] Y_MIN         = 10'd0,
   parameter logic [9:0] Y_GROUND      = 10'd400,
   parameter logic [9:0] DUCK_W        = 10'd20,
   parameter logic [9:0] DUCK_H        = 10'd16,
   parameter logic [9:0] X_STEP        = 10'd2,
   parameter logic [9:0] Y_STEP        = 10'd2,
   parameter logic [9:0] FALL_STEP     = 10'd3,
   parameter logic [3:0] FLAP_FRAMES   = 4'd8,
   parameter logic [5:0] SHOT_FRAMES   = 6'd30,
   parameter logic [9:0] ESCAPE_FRAMES = 10'd600
) (
   input  logic              Clk,
   input  logic              Reset,
   duck_flight_ctrl_if.slave bus
);

   localparam logic [9:0] X_LIM  = X_MAX - DUCK_W + 10'd1;
   localparam logic [9:0] Y_LIM  = Y_GROUND - DUCK_H;
   localparam logic [9:0] X_HOME = 10'd320;

   duck_state_t state_q, state_d;
   logic [9:0]  x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic        xdir_q, xdir_d;      // 1 = moving right
   logic        ydir_q, ydir_d;      // 1 = moving up (y decreasing)
   logic [3:0]  flap_q, flap_d;
   logic        wing_q, wing_d;
   logic [9:0]  esc_q, esc_d;
   logic [5:0]  shot_cnt_q, shot_cnt_d;
   logic        hit_q, hit_d;
   logic        escaped_q, escaped_d;
   logic        landed_q, landed_d;

   logic        tick;
   logic [10:0] x_sum;
   logic [10:0] y_sum;
   logic [10:0] fall_sum;
   logic [10:0] dx;
   logic [10:0] dy;
   logic        in_box;
   logic        flap_wrap;
   logic [9:0]  esc_inc;

   frame_tick_sync u_tick (
      .clk_i   (Clk),
      .rst_i   (Reset),
      .async_i (bus.frame_clk),
      .tick_o  (tick)
   );

   // 11-bit sums so a step past the bottom/right bound is seen instead of wrapping.
   assign x_sum    = {1'b0, x_q} + {1'b0, X_STEP};
   assign y_sum    = {1'b0, y_q} + {1'b0, Y_STEP};
   assign fall_sum = {1'b0, y_q} + {1'b0, FALL_STEP};

   // A borrow (bit 10) means the shot lies left of / above the sprite: a miss.
   assign dx     = {1'b0, bus.shot_x} - {1'b0, x_q};
   assign dy     = {1'b0, bus.shot_y} - {1'b0, y_q};
   assign in_box = !dx[10] && (dx[9:0] < DUCK_W) && !dy[10] && (dy[9:0] < DUCK_H);

   assign flap_wrap = (flap_q == FLAP_FRAMES - 4'd1);
   assign esc_inc   = esc_q + 10'd1;

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      xdir_d     = xdir_q;
      ydir_d     = ydir_q;
      flap_d     = flap_q;
      wing_d     = wing_q;
      esc_d      = esc_q;
      shot_cnt_d = shot_cnt_q;
      hit_d      = 1'b0;
      escaped_d  = 1'b0;
      landed_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.launch) begin
               state_d    = FLY;
               x_d        = clamp_x(bus.start_x, X_MIN, X_LIM);
               y_d        = Y_LIM;
               xdir_d     = bus.dir_seed[0];
               ydir_d     = bus.dir_seed[1];
               flap_d     = '0;
               wing_d     = 1'b0;
               esc_d      = '0;
               shot_cnt_d = '0;
            end
         end

         FLY: begin
            // The hit is checked first so a coincident tick moves nothing.
            if (bus.shot_valid && in_box) begin
               hit_d      = 1'b1;
               state_d    = SHOT;
               shot_cnt_d = '0;
            end else if (tick) begin
               if (xdir_q) begin
                  if (x_sum > {1'b0, X_LIM}) begin
                     x_d    = X_LIM;
                     xdir_d = 1'b0;
                  end else begin
                     x_d = x_sum[9:0];
                  end
               end else begin
                  // x - step < X_MIN, written without a subtraction that could borrow.
                  if ({1'b0, x_q} < ({1'b0, X_MIN} + {1'b0, X_STEP})) begin
                     x_d    = X_MIN;
                     xdir_d = 1'b1;
                  end else begin
                     x_d = x_q - X_STEP;
                  end
               end

               if (ydir_q) begin
                  if ({1'b0, y_q} < ({1'b0, Y_MIN} + {1'b0, Y_STEP})) begin
                     y_d    = Y_MIN;
                     ydir_d = 1'b0;
                  end else begin
                     y_d = y_q - Y_STEP;
                  end
               end else begin
                  if (y_sum > {1'b0, Y_LIM}) begin
                     y_d    = Y_LIM;
                     ydir_d = 1'b1;
                  end else begin
                     y_d = y_sum[9:0];
                  end
               end

               flap_d = flap_wrap ? 4'd0 : flap_q + 4'd1;
               wing_d = wing_q ^ flap_wrap;
               esc_d  = esc_inc;
               if (esc_inc == ESCAPE_FRAMES)
                  state_d = ESCAPE;
            end
         end

         SHOT: begin
            if (tick) begin
               if (shot_cnt_q == SHOT_FRAMES - 6'd1) begin
                  shot_cnt_d = '0;
                  state_d    = FALL;
               end else begin
                  shot_cnt_d = shot_cnt_q + 6'd1;
               end
            end
         end

         FALL: begin
            if (tick) begin
               if (fall_sum >= {1'b0, Y_LIM}) begin
                  y_d      = Y_LIM;
                  landed_d = 1'b1;
                  state_d  = IDLE;
               end else begin
                  y_d = fall_sum[9:0];
               end
            end
         end

         ESCAPE: begin
            if (tick) begin
               flap_d = flap_wrap ? 4'd0 : flap_q + 4'd1;
               wing_d = wing_q ^ flap_wrap;
               if (y_q < Y_STEP) begin
                  y_d       = 10'd0;
                  escaped_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  y_d = y_q - Y_STEP;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= IDLE;
         x_q        <= X_HOME;
         y_q        <= Y_LIM;
         xdir_q     <= 1'b0;
         ydir_q     <= 1'b0;
         flap_q     <= '0;
         wing_q     <= 1'b0;
         esc_q      <= '0;
         shot_cnt_q <= '0;
         hit_q      <= 1'b0;
         escaped_q  <= 1'b0;
         landed_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         xdir_q     <= xdir_d;
         ydir_q     <= ydir_d;
         flap_q     <= flap_d;
         wing_q     <= wing_d;
         esc_q      <= esc_d;
         shot_cnt_q <= shot_cnt_d;
         hit_q      <= hit_d;
         escaped_q  <= escaped_d;
         landed_q   <= landed_d;
      end
   end

   always_comb begin
      bus.sprite_base = FRAME_FLY_A;
      case (state_q)
         FLY, ESCAPE: bus.sprite_base = wing_q ? FRAME_FLY_B : FRAME_FLY_A;
         SHOT:        bus.sprite_base = FRAME_SHOT;
         FALL:        bus.sprite_base = FRAME_FALL;
         default:     bus.sprite_base = FRAME_FLY_A;
      endcase
   end

   assign bus.duck_x     = x_q;
   assign bus.duck_y     = y_q;
   assign bus.duck_state = state_q;
   assign bus.active     = (state_q != IDLE);
   assign bus.hit        = hit_q;
   assign bus.escaped    = escaped_q;
   assign bus.landed     = landed_q;

endmodule

// File: tb/tb_duck_flight_ctrl.sv
// Self-checking bench for duck_flight_ctrl with a behavioural integer model of the duck.
// Latency: frame ticks are given ample settle time before outputs are compared.
// Backpressure: none.
module tb_duck_flight_ctrl;
   import duck_pkg::*;

   logic Clk;
   logic Reset;
   duck_flight_ctrl_if bus ();

   duck_flight_ctrl dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   int total = 0;
   int bad   = 0;

   // Event monitor: counts pulses and records position at the end-of-flight pulses.
   int         n_hit = 0, n_land = 0, n_esc = 0, n_multi = 0;
   logic [9:0] land_y = '0, esc_y = '1;
   always @(negedge Clk) begin
      if (bus.hit)     n_hit++;
      if (bus.landed)  begin n_land++; land_y = bus.duck_y; end
      if (bus.escaped) begin n_esc++;  esc_y  = bus.duck_y; end
      if (int'(bus.hit) + int'(bus.landed) + int'(bus.escaped) > 1) n_multi++;
   end

   // ---------------- behavioural model (plain integer screen geometry) ----------------
   duck_state_t m_st;
   int  m_x, m_y, m_fly, m_flap, m_shot;
   bit  m_right, m_up;
   int  e_hit = 0, e_land = 0, e_esc = 0;

   task automatic model_reset();
      m_st = IDLE; m_x = 320; m_y = 384; m_fly = 0; m_flap = 0; m_shot = 0;
      m_right = 0; m_up = 0;
   endtask

   task automatic model_launch(input int sx, input logic [1:0] seed);
      m_st = FLY; m_x = (sx > 620) ? 620 : sx; m_y = 384;
      m_right = seed[0]; m_up = seed[1]; m_fly = 0; m_flap = 0;
   endtask

   function automatic bit model_in_box(input int sx, input int sy);
      return (m_st == FLY) && (sx - m_x >= 0) && (sx - m_x < 20) && (sy - m_y >= 0) && (sy - m_y < 16);
   endfunction

   task automatic model_hit();
      m_st = SHOT; m_shot = 0; e_hit++;
   endtask

   task automatic model_tick();
      case (m_st)
         FLY: begin
            m_x += m_right ? 2 : -2;
            if (m_x > 620) begin m_x = 620; m_right = 0; end
            else if (m_x < 0) begin m_x = 0; m_right = 1; end
            m_y += m_up ? -2 : 2;
            if (m_y < 0) begin m_y = 0; m_up = 0; end
            else if (m_y > 384) begin m_y = 384; m_up = 1; end
            m_flap++; m_fly++;
            if (m_fly == 600) m_st = ESCAPE;
         end
         SHOT: begin
            m_shot++;
            if (m_shot == 30) m_st = FALL;
         end
         FALL: begin
            m_y += 3;
            if (m_y >= 384) begin m_y = 384; e_land++; m_st = IDLE; end
         end
         ESCAPE: begin
            m_flap++;
            if (m_y < 2) begin m_y = 0; e_esc++; m_st = IDLE; end
            else m_y -= 2;
         end
         default: ;
      endcase
   endtask

   function automatic int model_sprite();
      case (m_st)
         FLY, ESCAPE: return ((m_flap / 8) % 2 == 1) ? 320 : 0;
         SHOT:        return 640;
         FALL:        return 960;
         default:     return 0;
      endcase
   endfunction

   // ---------------- stimulus helpers (no checking inside) ----------------
   task automatic apply_reset();
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      model_reset();
      @(negedge Clk);
   endtask

   task automatic do_launch(input int sx, input logic [1:0] seed);
      @(negedge Clk);
      bus.launch = 1'b1; bus.start_x = 10'(sx); bus.dir_seed = seed;
      @(negedge Clk);
      bus.launch = 1'b0;
      @(negedge Clk);
      if (m_st == IDLE) model_launch(sx, seed);
   endtask

   task automatic do_shot(input int sx, input int sy);
      @(negedge Clk);
      bus.shot_valid = 1'b1; bus.shot_x = 10'(sx); bus.shot_y = 10'(sy);
      @(negedge Clk);
      bus.shot_valid = 1'b0;
      repeat (2) @(negedge Clk);
      if (model_in_box(sx, sy)) model_hit();
   endtask

   // mode 0: plain tick; 1: launch in the tick cycle; 2: shot in the tick cycle.
   task automatic do_tick(input int mode, input int sx, input int sy, input logic [1:0] seed);
      @(negedge Clk);
      bus.frame_clk = 1'b1;
      repeat (2) @(negedge Clk);
      if (mode == 1) begin
         bus.launch = 1'b1; bus.start_x = 10'(sx); bus.dir_seed = seed;
      end else if (mode == 2) begin
         bus.shot_valid = 1'b1; bus.shot_x = 10'(sx); bus.shot_y = 10'(sy);
      end
      @(negedge Clk);
      bus.launch = 1'b0; bus.shot_valid = 1'b0;
      repeat (3) @(negedge Clk);
      bus.frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
      if (mode == 1 && m_st == IDLE) model_launch(sx, seed);
      else if (mode == 2 && model_in_box(sx, sy)) model_hit();
      else model_tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      apply_reset();
      total++; if (bus.duck_state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", bus.duck_state, IDLE); end
      total++; if (bus.duck_x !== 10'd320) begin bad++; $display("FAIL reset_x: got %0d want 320", bus.duck_x); end
      total++; if (bus.duck_y !== 10'd384) begin bad++; $display("FAIL reset_y: got %0d want 384", bus.duck_y); end
      total++; if (bus.sprite_base !== FRAME_FLY_A) begin bad++; $display("FAIL reset_sprite: got %0d want %0d", bus.sprite_base, FRAME_FLY_A); end
      total++; if (bus.active !== 1'b0) begin bad++; $display("FAIL reset_active: got %0b want 0", bus.active); end
      total++; if ({bus.hit, bus.landed, bus.escaped} !== 3'b000) begin bad++; $display("FAIL reset_pulses: got %b want 000", {bus.hit, bus.landed, bus.escaped}); end
   endtask

   task automatic test_fly_random();
      for (int t = 0; t < 6; t++) begin
         int sx, n;
         logic [1:0] seed;
         apply_reset();
         sx   = (t == 0) ? 100 : int'($urandom_range(0, 1023));
         seed = (t == 0) ? 2'b01 : 2'($urandom_range(0, 3));
         n    = (t == 0) ? 5 : int'($urandom_range(1, 40));
         do_launch(sx, seed);
         total++; if (bus.duck_x !== 10'(m_x) || bus.duck_state !== FLY) begin bad++; $display("FAIL launch_pos[%0d]: got x=%0d st=%0d want x=%0d st=%0d", t, bus.duck_x, bus.duck_state, m_x, FLY); end
         for (int k = 0; k < n; k++) do_tick(0, 0, 0, 2'b00);
         total++; if (bus.duck_x !== 10'(m_x)) begin bad++; $display("FAIL fly_x[%0d]: got %0d want %0d", t, bus.duck_x, m_x); end
         total++; if (bus.duck_y !== 10'(m_y)) begin bad++; $display("FAIL fly_y[%0d]: got %0d want %0d", t, bus.duck_y, m_y); end
         total++; if (bus.sprite_base !== 19'(model_sprite())) begin bad++; $display("FAIL fly_sprite[%0d]: got %0d want %0d", t, bus.sprite_base, model_sprite()); end
         total++; if (bus.active !== 1'b1) begin bad++; $display("FAIL fly_active[%0d]: got %0b want 1", t, bus.active); end
      end
   endtask

   task automatic test_bounce();
      apply_reset();
      do_tick(1, 619, 0, 2'b01);   // launch wins over the coincident tick
      total++; if (bus.duck_x !== 10'd619) begin bad++; $display("FAIL launch_on_tick_x: got %0d want 619", bus.duck_x); end
      do_tick(0, 0, 0, 2'b00);
      total++; if (bus.duck_x !== 10'd620) begin bad++; $display("FAIL right_clamp: got %0d want 620", bus.duck_x); end
      do_tick(0, 0, 0, 2'b00);
      total++; if (bus.duck_x !== 10'd618 || bus.duck_x !== 10'(m_x)) begin bad++; $display("FAIL right_turn: got %0d want 618", bus.duck_x); end
      apply_reset();
      do_launch(1, 2'b10);
      do_tick(0, 0, 0, 2'b00);
      total++; if (bus.duck_x !== 10'd0) begin bad++; $display("FAIL left_clamp: got %0d want 0", bus.duck_x); end
      do_tick(0, 0, 0, 2'b00);
      total++; if (bus.duck_x !== 10'd2 || bus.duck_y !== 10'(m_y)) begin bad++; $display("FAIL left_turn: got x=%0d y=%0d want x=2 y=%0d", bus.duck_x, bus.duck_y, m_y); end
   endtask

   task automatic test_hit_miss_fall();
      int miss_x[4], miss_y[4];
      int ox, oy;
      apply_reset();
      do_launch(int'($urandom_range(40, 580)), 2'($urandom_range(0, 3)));
      repeat (3) do_tick(0, 0, 0, 2'b00);
      miss_x = '{m_x + 20, m_x - 1, m_x, m_x + 19};
      miss_y = '{m_y, m_y + 15, m_y + 16, m_y - 1};
      for (int i = 0; i < 4; i++) begin
         do_shot(miss_x[i], miss_y[i]);
         total++; if (bus.duck_state !== FLY || n_hit != e_hit) begin bad++; $display("FAIL miss[%0d]: got st=%0d hits=%0d want st=%0d hits=%0d", i, bus.duck_state, n_hit, FLY, e_hit); end
      end
      ox = int'($urandom_range(0, 19)); oy = int'($urandom_range(0, 15));
      do_shot(m_x + ox, m_y + oy);
      total++; if (bus.duck_state !== SHOT || n_hit != e_hit) begin bad++; $display("FAIL hit: got st=%0d hits=%0d want st=%0d hits=%0d", bus.duck_state, n_hit, SHOT, e_hit); end
      total++; if (bus.sprite_base !== FRAME_SHOT || bus.duck_x !== 10'(m_x)) begin bad++; $display("FAIL hit_frozen: got spr=%0d x=%0d want spr=%0d x=%0d", bus.sprite_base, bus.duck_x, FRAME_SHOT, m_x); end
      do_shot(m_x, m_y);
      total++; if (n_hit != e_hit) begin bad++; $display("FAIL shot_in_shot: got hits=%0d want %0d", n_hit, e_hit); end
      repeat (29) do_tick(0, 0, 0, 2'b00);
      total++; if (bus.duck_state !== SHOT) begin bad++; $display("FAIL shot_hold29: got %0d want %0d", bus.duck_state, SHOT); end
      do_tick(0, 0, 0, 2'b00);
      total++; if (bus.duck_state !== FALL || bus.sprite_base !== FRAME_FALL) begin bad++; $display("FAIL shot_to_fall: got st=%0d spr=%0d want st=%0d spr=%0d", bus.duck_state, bus.sprite_base, FALL, FRAME_FALL); end
      for (int i = 0; i < 200 && m_st != IDLE; i++) begin
         do_tick(0, 0, 0, 2'b00);
         total++; if (bus.duck_y !== 10'(m_y)) begin bad++; $display("FAIL fall_y[%0d]: got %0d want %0d", i, bus.duck_y, m_y); end
      end
      total++; if (bus.duck_state !== IDLE || bus.active !== 1'b0) begin bad++; $display("FAIL landed_state: got st=%0d act=%0b want st=%0d act=0", bus.duck_state, bus.active, IDLE); end
      total++; if (n_land != e_land || land_y !== 10'd384) begin bad++; $display("FAIL landed_pulse: got n=%0d y=%0d want n=%0d y=384", n_land, land_y, e_land); end
   endtask

   task automatic test_hit_on_tick();
      int px, py;
      apply_reset();
      do_launch(int'($urandom_range(0, 620)), 2'($urandom_range(0, 3)));
      repeat (4) do_tick(0, 0, 0, 2'b00);
      px = m_x; py = m_y;
      do_tick(2, px + int'($urandom_range(0, 19)), py + int'($urandom_range(0, 15)), 2'b00);
      total++; if (bus.duck_x !== 10'(px) || bus.duck_y !== 10'(py)) begin bad++; $display("FAIL hit_tick_pos: got (%0d,%0d) want (%0d,%0d)", bus.duck_x, bus.duck_y, px, py); end
      total++; if (bus.duck_state !== SHOT || n_hit != e_hit) begin bad++; $display("FAIL hit_tick_state: got st=%0d hits=%0d want st=%0d hits=%0d", bus.duck_state, n_hit, SHOT, e_hit); end
   endtask

   task automatic test_escape();
      apply_reset();
      do_launch(int'($urandom_range(0, 1023)), 2'($urandom_range(0, 3)));
      repeat (599) do_tick(0, 0, 0, 2'b00);
      total++; if (bus.duck_state !== FLY || bus.duck_x !== 10'(m_x) || bus.duck_y !== 10'(m_y)) begin bad++; $display("FAIL fly599: got st=%0d (%0d,%0d) want st=%0d (%0d,%0d)", bus.duck_state, bus.duck_x, bus.duck_y, FLY, m_x, m_y); end
      do_tick(0, 0, 0, 2'b00);
      total++; if (bus.duck_state !== ESCAPE) begin bad++; $display("FAIL escape_enter: got %0d want %0d", bus.duck_state, ESCAPE); end
      do_launch(5, 2'b11);
      total++; if (bus.duck_state !== ESCAPE || bus.duck_x !== 10'(m_x)) begin bad++; $display("FAIL launch_in_escape: got st=%0d x=%0d want st=%0d x=%0d", bus.duck_state, bus.duck_x, ESCAPE, m_x); end
      do_shot(m_x + 1, m_y + 1);
      total++; if (n_hit != e_hit || bus.duck_state !== ESCAPE) begin bad++; $display("FAIL shot_in_escape: got hits=%0d st=%0d want hits=%0d st=%0d", n_hit, bus.duck_state, e_hit, ESCAPE); end
      for (int i = 0; i < 250 && m_st != IDLE; i++) begin
         do_tick(0, 0, 0, 2'b00);
         total++; if (bus.duck_y !== 10'(m_y) || bus.duck_x !== 10'(m_x) || bus.duck_state !== m_st) begin bad++; $display("FAIL escape_step[%0d]: got st=%0d (%0d,%0d) want st=%0d (%0d,%0d)", i, bus.duck_state, bus.duck_x, bus.duck_y, m_st, m_x, m_y); end
         total++; if (bus.sprite_base !== 19'(model_sprite())) begin bad++; $display("FAIL escape_sprite[%0d]: got %0d want %0d", i, bus.sprite_base, model_sprite()); end
      end
      total++; if (bus.duck_state !== IDLE || n_esc != e_esc || esc_y !== 10'd0) begin bad++; $display("FAIL escaped_pulse: got st=%0d n=%0d y=%0d want st=%0d n=%0d y=0", bus.duck_state, n_esc, esc_y, IDLE, e_esc); end
   endtask

   task automatic test_reset_mid_fall();
      apply_reset();
      do_launch(300, 2'b10);
      repeat (20) do_tick(0, 0, 0, 2'b00);
      do_shot(m_x + 3, m_y + 3);
      repeat (32) do_tick(0, 0, 0, 2'b00);
      total++; if (bus.duck_state !== FALL || bus.duck_y !== 10'(m_y)) begin bad++; $display("FAIL pre_reset_fall: got st=%0d y=%0d want st=%0d y=%0d", bus.duck_state, bus.duck_y, FALL, m_y); end
      @(posedge Clk);
      #3 Reset = 1'b1;
      #1;
      total++; if (bus.duck_state !== IDLE || bus.active !== 1'b0) begin bad++; $display("FAIL async_reset_state: got st=%0d act=%0b want st=%0d act=0", bus.duck_state, bus.active, IDLE); end
      total++; if (bus.duck_x !== 10'd320 || bus.duck_y !== 10'd384 || bus.sprite_base !== FRAME_FLY_A) begin bad++; $display("FAIL async_reset_pos: got (%0d,%0d) spr=%0d want (320,384) spr=0", bus.duck_x, bus.duck_y, bus.sprite_base); end
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      model_reset();
      repeat (15) @(negedge Clk);
      total++; if (n_land != e_land || bus.duck_state !== IDLE) begin bad++; $display("FAIL no_landed_after_reset: got n=%0d st=%0d want n=%0d st=%0d", n_land, bus.duck_state, e_land, IDLE); end
      total++; if (n_multi != 0) begin bad++; $display("FAIL pulse_overlap: got %0d want 0", n_multi); end
   endtask

   initial begin
      Reset          = 1'b1;
      bus.frame_clk  = 1'b0;
      bus.launch     = 1'b0;
      bus.start_x    = '0;
      bus.dir_seed   = '0;
      bus.shot_valid = 1'b0;
      bus.shot_x     = '0;
      bus.shot_y     = '0;
      model_reset();
      test_reset();
      test_fly_random();
      test_bounce();
      test_hit_miss_fall();
      test_hit_on_tick();
      test_escape();
      test_reset_mid_fall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
